// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: sync, data enable, coordinates, line/frame/line-match pulses.
// Define VGA_TIMING_REG_OUT_EN to add one aligned register stage on every output (+1 clk latency).
module vga_timing_gen #(
  parameter int   H_ACTIVE = 32'd1280,
  parameter int   H_FP     = 32'd48,
  parameter int   H_SYNC   = 32'd112,
  parameter int   H_BP     = 32'd248,
  parameter int   V_ACTIVE = 32'd1024,
  parameter int   V_FP     = 32'd1,
  parameter int   V_SYNC   = 32'd3,
  parameter int   V_BP     = 32'd38,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   HCW      = 32'd12,
  parameter int   VCW      = 32'd11,
  parameter int   FCW      = 32'd8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [VCW-1:0] irq_line,
  output logic           hsync,
  output logic           vsync,
  output logic           blank_n,
  output logic           de,
  output logic [HCW-1:0] x,
  output logic [VCW-1:0] y,
  output logic           sol,
  output logic           sof,
  output logic           line_hit,
  output logic [FCW-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 32'd1);
  localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 32'd1);
  localparam logic [HCW-1:0] H_ONE  = {{(HCW-1){1'b0}}, 1'b1};
  localparam logic [VCW-1:0] V_ONE  = {{(VCW-1){1'b0}}, 1'b1};
  localparam logic [FCW-1:0] F_ONE  = {{(FCW-1){1'b0}}, 1'b1};

  // One extra bit so a sync region ending exactly at 2^HCW / 2^VCW still compares correctly
  localparam logic [HCW:0] H_ACT_W = (HCW+1)'(H_ACTIVE);
  localparam logic [HCW:0] HS_BEG  = (HCW+1)'(H_ACTIVE + H_FP);
  localparam logic [HCW:0] HS_END  = (HCW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCW:0] V_ACT_W = (VCW+1)'(V_ACTIVE);
  localparam logic [VCW:0] VS_BEG  = (VCW+1)'(V_ACTIVE + V_FP);
  localparam logic [VCW:0] VS_END  = (VCW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [HCW-1:0] hcnt_r;
  logic [VCW-1:0] vcnt_r;
  logic           sol_r;
  logic           sof_r;
  logic           hit_r;
  logic [FCW-1:0] frame_cnt_r;

  logic           h_wrap_s;
  logic           v_wrap_s;
  logic [HCW-1:0] h_next_s;
  logic [VCW-1:0] v_next_s;
  logic           de_s;
  logic           hs_act_s;
  logic           vs_act_s;
  logic           hsync_s;
  logic           vsync_s;

  // Next-count computation for both raster counters
  always_comb begin
    h_wrap_s = (hcnt_r == H_LAST);
    v_wrap_s = (vcnt_r == V_LAST);
    if (h_wrap_s) begin
      h_next_s = {HCW{1'b0}};
    end else begin
      h_next_s = hcnt_r + H_ONE;
    end
    if (v_wrap_s) begin
      v_next_s = {VCW{1'b0}};
    end else begin
      v_next_s = vcnt_r + V_ONE;
    end
  end

  // Raster counters, start-of-line/frame pulses, line match and frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_r      <= H_LAST;
      vcnt_r      <= V_LAST;
      sol_r       <= 1'b0;
      sof_r       <= 1'b0;
      hit_r       <= 1'b0;
      frame_cnt_r <= {FCW{1'b0}};
    end else if (en) begin
      hcnt_r <= h_next_s;
      if (h_wrap_s) begin
        vcnt_r <= v_next_s;
      end
      sol_r <= h_wrap_s;
      sof_r <= h_wrap_s && v_wrap_s;
      hit_r <= h_wrap_s && (v_next_s == irq_line);
      if (h_wrap_s && v_wrap_s) begin
        frame_cnt_r <= frame_cnt_r + F_ONE;
      end
    end else begin
      sol_r <= 1'b0;
      sof_r <= 1'b0;
      hit_r <= 1'b0;
    end
  end

  assign de_s     = ({1'b0, hcnt_r} < H_ACT_W) && ({1'b0, vcnt_r} < V_ACT_W);
  assign hs_act_s = ({1'b0, hcnt_r} >= HS_BEG) && ({1'b0, hcnt_r} < HS_END);
  assign vs_act_s = ({1'b0, vcnt_r} >= VS_BEG) && ({1'b0, vcnt_r} < VS_END);
  assign hsync_s  = hs_act_s ? HS_POL : ~HS_POL;
  assign vsync_s  = vs_act_s ? VS_POL : ~VS_POL;

`ifdef VGA_TIMING_REG_OUT_EN
  // Aligned output stage; frame_cnt delayed with it so it still changes together with sof
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync     <= ~HS_POL;
      vsync     <= ~VS_POL;
      de        <= 1'b0;
      blank_n   <= 1'b0;
      x         <= H_LAST;
      y         <= V_LAST;
      sol       <= 1'b0;
      sof       <= 1'b0;
      line_hit  <= 1'b0;
      frame_cnt <= {FCW{1'b0}};
    end else begin
      hsync     <= hsync_s;
      vsync     <= vsync_s;
      de        <= de_s;
      blank_n   <= de_s;
      x         <= hcnt_r;
      y         <= vcnt_r;
      sol       <= sol_r;
      sof       <= sof_r;
      line_hit  <= hit_r;
      frame_cnt <= frame_cnt_r;
    end
  end
`else
  assign hsync     = hsync_s;
  assign vsync     = vsync_s;
  assign de        = de_s;
  assign blank_n   = de_s;
  assign x         = hcnt_r;
  assign y         = vcnt_r;
  assign sol       = sol_r;
  assign sof       = sof_r;
  assign line_hit  = hit_r;
  assign frame_cnt = frame_cnt_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen in small mode (H=8/2/2/2, V=4/1/1/1, HS_POL=0).
// Honours VGA_TIMING_REG_OUT_EN by expecting a one-clock shift of all outputs.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [3:0] x;
    logic [2:0] y;
    logic       sol;
    logic       sof;
    logic       hit;
    logic [7:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [2:0] irq_line = 3'd3;
  logic       hsync, vsync, blank_n, de, sol, sof, line_hit;
  logic [3:0] x;
  logic [2:0] y;
  logic [7:0] frame_cnt;

  int n_vec = 0;
  int n_miss = 0;
  int sol_seen = 0;
  int sof_seen = 0;
  int hit_seen = 0;

  // Reference model state (small mode: H_TOTAL=14, V_TOTAL=7)
  int m_h = 13, m_v = 6, m_fc = 0;
  logic m_sol = 1'b0, m_sof = 1'b0, m_hit = 1'b0;
  exp_t q[$];

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .HCW(4), .VCW(3), .FCW(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .irq_line(irq_line),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .de(de),
    .x(x), .y(y), .sol(sol), .sof(sof), .line_hit(line_hit),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.hs  = !(m_h >= 10 && m_h < 12);
    e.vs  = (m_v == 5);
    e.de  = (m_h < 8) && (m_v < 4);
    e.x   = 4'(m_h);
    e.y   = 3'(m_v);
    e.sol = m_sol;
    e.sof = m_sof;
    e.hit = m_hit;
    e.fc  = 8'(m_fc);
    return e;
  endfunction

  // Apply one clock of stimulus, push the expected post-edge outputs, then count pulses.
  task automatic step(input logic r, input logic e, input logic [2:0] irq);
    exp_t cur;
    exp_t nxt;
    logic wrap;
    logic vwrap;
    rst = r; en = e; irq_line = irq;
    cur = model_out();
    if (r) begin
      m_h = 13; m_v = 6; m_fc = 0;
      m_sol = 1'b0; m_sof = 1'b0; m_hit = 1'b0;
    end else if (e) begin
      wrap  = (m_h == 13);
      vwrap = wrap && (m_v == 6);
      m_h   = wrap ? 0 : m_h + 1;
      if (wrap) m_v = (m_v == 6) ? 0 : m_v + 1;
      m_sol = wrap;
      m_sof = vwrap;
      m_hit = wrap && (m_v == int'(irq));
      if (vwrap) m_fc = (m_fc + 1) % 256;
    end else begin
      m_sol = 1'b0; m_sof = 1'b0; m_hit = 1'b0;
    end
    nxt = model_out();
`ifdef VGA_TIMING_REG_OUT_EN
    q.push_back(r ? nxt : cur);
`else
    q.push_back(nxt);
`endif
    @(posedge clk);
    #1;
    sol_seen += int'(sol);
    sof_seen += int'(sof);
    hit_seen += int'(line_hit);
  endtask

  // Monitor: every clock the DUT presents a new output set; pop and compare
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if ({hsync, vsync, de, blank_n, x, y, sol, sof, line_hit, frame_cnt} !==
          {e.hs, e.vs, e.de, e.de, e.x, e.y, e.sol, e.sof, e.hit, e.fc}) begin
        n_miss++;
        $display("FAIL scoreboard: got hs=%b vs=%b de=%b bn=%b x=%0d y=%0d sol=%b sof=%b hit=%b fc=%0d expected hs=%b vs=%b de=%b x=%0d y=%0d sol=%b sof=%b hit=%b fc=%0d at %0t",
                 hsync, vsync, de, blank_n, x, y, sol, sof, line_hit, frame_cnt,
                 e.hs, e.vs, e.de, e.x, e.y, e.sol, e.sof, e.hit, e.fc, $time);
      end
    end
  end

  // Hand-computed reset-state and first-pixel checks
  task automatic check_reset_state(input string tag);
    chk({tag, "_x"}, 32'(x), 32'd13);
    chk({tag, "_y"}, 32'(y), 32'd6);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd0);
    chk({tag, "_de"}, 32'(de), 32'd0);
    chk({tag, "_sol"}, 32'(sol), 32'd0);
    chk({tag, "_fc"}, 32'(frame_cnt), 32'd0);
  endtask

  task automatic release_and_check(input string tag);
    step(1'b0, 1'b1, 3'd3);
`ifdef VGA_TIMING_REG_OUT_EN
    step(1'b0, 1'b1, 3'd3);
`endif
    chk({tag, "_x0"}, 32'(x), 32'd0);
    chk({tag, "_y0"}, 32'(y), 32'd0);
    chk({tag, "_de0"}, 32'(de), 32'd1);
    chk({tag, "_sol0"}, 32'(sol), 32'd1);
    chk({tag, "_sof0"}, 32'(sof), 32'd1);
    chk({tag, "_fc1"}, 32'(frame_cnt), 32'd1);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'd3);
    check_reset_state("rst");
    release_and_check("start");

    sol_seen = 0; sof_seen = 0; hit_seen = 0;
    for (int i = 0; i < 98; i++) step(1'b0, 1'b1, 3'd3);
    chk("sol_per_frame", 32'(sol_seen), 32'd7);
    chk("hit_irq3", 32'(hit_seen), 32'd1);

    sol_seen = 0; hit_seen = 0;
    for (int i = 0; i < 98; i++) step(1'b0, 1'b1, 3'd7);
    chk("sol_per_frame2", 32'(sol_seen), 32'd7);
    chk("hit_irq_vtotal", 32'(hit_seen), 32'd0);

    sol_seen = 0; sof_seen = 0;
    for (int i = 0; i < 196; i++) step(1'b0, (i % 2) == 0, 3'd3);
    chk("sol_half_rate", 32'(sol_seen), 32'd7);
    chk("sof_half_rate", 32'(sof_seen), 32'd1);

    // 256 frames: frame_cnt wraps through 255 -> 0
    for (int i = 0; i < 256 * 98; i++) step(1'b0, 1'b1, 3'd2);

    for (int i = 0; i < 300; i++) step(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));

    // Reset mid-frame just after a line wrap, with en low, so a pending sol is cleared
    guard = 0;
    while (!(m_v == 5 && m_h == 0) && guard < 400) begin
      step(1'b0, 1'b1, 3'd3);
      guard++;
    end
    chk("midframe_reach", 32'(guard < 400), 32'd1);
    step(1'b1, 1'b0, 3'd3);
    check_reset_state("midrst");
    release_and_check("restart");
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 3'd3);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator that replaces the fixed-mode H/V sync pair in the display pipeline. It produces hsync, vsync, blanking, data-enable, raster coordinates, line/frame start pulses, a frame counter and a programmable line-match pulse, all from a single clock domain. Downstream pixel/colour logic (game renderer, overlays) consumes x/y/de instead of keeping its own row/column counters. A pixel-clock enable allows one fast clock to drive lower-rate modes.

## Interface
Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 48, horizontal front porch (pixels)
- H_SYNC, 112, hsync width (pixels)
- H_BP, 248, horizontal back porch (pixels)
- V_ACTIVE, 1024, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vsync width (lines)
- V_BP, 38, vertical back porch (lines)
- HS_POL, 1, hsync asserted level (1 = active-high)
- VS_POL, 1, vsync asserted level
- HCW, 12, horizontal counter width; H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP must be ≤ 2^HCW
- VCW, 11, vertical counter width; V_TOTAL likewise ≤ 2^VCW
- FCW, 8, frame counter width

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  pixel enable; counters advance only on clk edges with en=1
- irq_line  in  VCW  line number for line_hit
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- blank_n  out  1  1 = inside active area (same as de)
- de  out  1  data enable
- x  out  HCW  current hcnt
- y  out  VCW  current vcnt
- sol  out  1  start-of-line pulse
- sof  out  1  start-of-frame pulse
- line_hit  out  1  line-match pulse
- frame_cnt  out  FCW  completed-frame count

## Operation
- hcnt counts 0..H_TOTAL-1; on en with hcnt=H_TOTAL-1, hcnt→0 and vcnt advances; vcnt counts 0..V_TOTAL-1, wraps to 0.
- Reset loads hcnt=H_TOTAL-1, vcnt=V_TOTAL-1 (back porch), so first en edge after reset lands on (0,0).
- de = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE); blank_n = de.
- hsync = HS_POL when H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
- vsync = VS_POL when V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL; vsync edges coincide with hcnt=0 transitions.
- x = hcnt, y = vcnt unconditionally; consumers qualify with de.
- sol: registered, high exactly one clk after each edge at which hcnt wraps to 0; low otherwise, even if en stays low.
- sof: as sol, only when vcnt also wraps to 0.
- line_hit: as sol, only when new vcnt == irq_line; irq_line ≥ V_TOTAL never fires. irq_line sampled at that edge.
- frame_cnt increments (mod 2^FCW) on the same edge sof is generated; first sof after reset increments 0→1.
- Reset values (all outputs, during and after rst until first en): hsync=~HS_POL, vsync=~VS_POL, de=blank_n=0, x=H_TOTAL-1, y=V_TOTAL-1, sol=sof=line_hit=0, frame_cnt=0.
- rst mid-frame: next edge forces reset state regardless of en; pending pulses cleared.

## Timing
- Counters registered; hsync/vsync/de/x/y are a decode of counter registers (0-cycle latency from counter) unless VGA_TIMING_REG_OUT_EN.
- Pulses are registered outputs, valid the clk cycle in which counters read (0, v).
- Line period H_TOTAL en-cycles; frame period H_TOTAL×V_TOTAL en-cycles (default 1688×1066 = 1,799,408).
- en=0: all counters, decoded outputs hold; pulses low.

## Configuration
- VGA_TIMING_REG_OUT_EN defined: hsync, vsync, de, blank_n, x, y, sol, sof, line_hit pass through one extra clk register stage (updated every clk, reset to reset values above); all outputs stay mutually aligned, +1 clk latency; frame_cnt aligned with sof.
- Undefined: decode outputs combinational from counters as specified; no extra latency.

## Test plan
- Reset: hold rst 3 clk with en=1 -> hsync=0, vsync=0, de=0, x=1687, y=1065, frame_cnt=0; first en edge after release -> x=0, y=0, de=1, sof=sol=1 for one clk, frame_cnt=1.
- Default line: en=1 constantly -> sol every 1688 clk; hsync high exactly for x=1328..1439 (112 clk); de high 1280 clk per active line.
- Small mode H=8/2/2/2, V=4/1/1/1, HS_POL=0: frame = 14×7 = 98 clk; hsync low x=10..11; vsync asserted y=5 only; frame_cnt wraps 255→0 after 256 frames with FCW=8.
- en=1 every other clk -> line period 2×H_TOTAL clk; sol/sof still exactly one clk wide.
- irq_line=3 -> line_hit once per frame, coincident with sol at y=3; irq_line=V_TOTAL -> never.
- rst asserted at y=500 mid-line -> next clk matches reset values; restart sequence as scenario 1; with VGA_TIMING_REG_OUT_EN all scenarios repeated expecting +1 clk shift.
